// File: rtl/shift_add_mult_pkg.sv
// Shared types and build options for the shift-and-add multiplier.
// Define SHIFT_ADD_MULT_SIGNED_EN for the two's complement build.
package mult_pkg;

    localparam int NUM_BITS_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

endpackage

// File: rtl/shift_add_mult_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface shift_add_mult_if #(
    parameter int num_bits = mult_pkg::NUM_BITS_DEF
);
    logic                    start;
    logic [num_bits-1:0]     a;
    logic [num_bits-1:0]     b;
    logic                    busy;
    logic                    done;
    logic [2*num_bits-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_step.sv
// One combinational shift-and-add step: next {acc_hi,mplr} from the current one.
// SHIFT_ADD_MULT_SIGNED_EN selects sign extension, arithmetic shift and final-step subtract.
module shift_add_step
    import mult_pkg::*;
#(
    parameter int num_bits = NUM_BITS_DEF
) (
    input  logic [num_bits:0]   acc_hi,
    input  logic [num_bits-1:0] mplr,
    input  logic [num_bits-1:0] mcand,
    input  logic                last,
    output logic [num_bits:0]   acc_hi_nxt,
    output logic [num_bits-1:0] mplr_nxt
);
    logic [num_bits:0] addend;
    logic [num_bits:0] sum;

    always_comb begin
        addend = {SIGNED_EN & mcand[num_bits-1], mcand};
        // The multiplier MSB carries negative weight in the signed build
        if (!mplr[0])
            sum = acc_hi;
        else if (SIGNED_EN && last)
            sum = acc_hi - addend;
        else
            sum = acc_hi + addend;
        acc_hi_nxt = {SIGNED_EN & sum[num_bits], sum[num_bits:1]};
        mplr_nxt   = {sum[0], mplr[num_bits-1:1]};
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, 2*num_bits product.
// Signed operation is selected at build time by SHIFT_ADD_MULT_SIGNED_EN.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int num_bits = NUM_BITS_DEF
) (
    input  logic           clk,
    input  logic           reset,
    shift_add_mult_if.slave bus
);
    localparam int             CW       = $clog2(num_bits + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(num_bits - 1);

    mult_state_t          state;
    logic [CW-1:0]        cnt;
    logic [num_bits:0]    acc_hi;
    logic [num_bits:0]    acc_hi_nxt;
    logic [num_bits-1:0]  mcand;
    logic [num_bits-1:0]  mplr;
    logic [num_bits-1:0]  mplr_nxt;
    logic                 last;

    assign last = (cnt == LAST_CNT);

    shift_add_step #(.num_bits(num_bits)) u_step (
        .acc_hi     (acc_hi),
        .mplr       (mplr),
        .mcand      (mcand),
        .last       (last),
        .acc_hi_nxt (acc_hi_nxt),
        .mplr_nxt   (mplr_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            mcand       <= '0;
            mplr        <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        bus.busy <= 1'b1;
                        mcand    <= bus.a;
                        mplr     <= bus.b;
                        acc_hi   <= '0;
                        cnt      <= '0;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                RUN: begin
                    acc_hi <= acc_hi_nxt;
                    mplr   <= mplr_nxt;
                    cnt    <= cnt + CW'(1);
                    // Product is taken from the step output so done and result line up
                    if (last) begin
                        state       <= DONE;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.product <= {acc_hi_nxt[num_bits-1:0], mplr_nxt};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: directed corner cases plus random operands.
module tb_shift_add_mult;
    import mult_pkg::*;

    localparam int N = 8;
    localparam int P = 2 * N;

    typedef struct {
        logic [P-1:0] p;
        int unsigned  acc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [P-1:0] last_p = '0;

    shift_add_mult_if #(.num_bits(N)) bus();
    shift_add_mult #(.num_bits(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [P-1:0] ref_mul(logic [N-1:0] x, logic [N-1:0] y);
        longint m;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        m = longint'($signed(x)) * longint'($signed(y));
`else
        m = longint'(x) * longint'(y);
`endif
        return m[P-1:0];
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    // Expected busy/done/product are derived from the accept cycle of the oldest pending op
    always @(negedge clk) begin
        bit eb, ed;
        if (!reset) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_product", bus.product, 0);
        end else begin
            eb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + N);
            ed = (q.size() > 0) && (cyc == q[0].acc + N);
            chk("busy", bus.busy, eb);
            chk("done", bus.done, ed);
            if (ed) begin
                last_p = q[0].p;
                void'(q.pop_front());
            end
            chk("product", bus.product, last_p);
        end
    end

    task automatic drain(int bound);
        for (int i = 0; i < bound && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_op(logic [N-1:0] x, logic [N-1:0] y);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = x; bus.b = y;
        q.push_back('{ref_mul(x, y), cyc + 1});
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = N'($urandom); bus.b = N'($urandom);
        drain(N + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned acc0;
        logic [N-1:0] x, y;
        bus.start = 1'b1; bus.a = N'($urandom); bus.b = N'($urandom);
        repeat (4) @(posedge clk);
        #3 bus.start = 1'b0; reset = 1'b1;
        repeat (4) @(posedge clk);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
        do_op(8'hFD, 8'd5);
        do_op(8'h80, 8'h80);
        do_op(8'h7F, 8'hFF);
        do_op(8'd13, 8'd11);
`else
        do_op(8'd13, 8'd11);
        do_op(8'd255, 8'd255);
        do_op(8'd0, 8'd200);
        do_op(8'd1, 8'd255);
`endif

        // Back-to-back with start held; operand change mid-run must not leak into op 1
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd5;
        acc0 = cyc + 1;
        q.push_back('{ref_mul(8'd3, 8'd5), acc0});
        repeat (4) @(posedge clk); #1;
        bus.a = 8'd7; bus.b = 8'd9;
        q.push_back('{ref_mul(8'd7, 8'd9), acc0 + N + 1});
        while (cyc < acc0 + N + 1) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        drain(2 * N + 6);

        // Abort mid-run: outputs clear asynchronously and no done follows
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd100;
        q.push_back('{ref_mul(8'd100, 8'd100), cyc + 1});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        q.delete();
        last_p = '0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_product", bus.product, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (N + 3) @(posedge clk);
        do_op(8'd2, 8'd3);

        for (int i = 0; i < 24; i++) begin
            x = N'($urandom);
            y = N'($urandom);
            if ($urandom_range(0, 3) == 0) x = '1;
            if ($urandom_range(0, 3) == 0) y = ($urandom_range(0, 1) == 0) ? '0 : '1;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(x, y);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add multiplier for the arithmetic datapath. It sits upstream of the accumulator stage (`acc_sm`) and produces a `2*num_bits` product from two `num_bits` operands, one multiplier bit per clock. A start/busy/done handshake lets a controller issue an operation, wait, and then steer `product` into the accumulator or a load port.

## Interface
- `num_bits`, 8: operand width; legal range 2..32
- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-low reset (asserted at 0)
- `start` input 1: request; sampled only in IDLE or DONE
- `a` input `num_bits`: multiplicand; captured on an accepted start
- `b` input `num_bits`: multiplier; captured on an accepted start
- `busy` output 1: high while in RUN
- `done` output 1: one-cycle pulse in DONE
- `product` output `2*num_bits`: result register; holds until the next completion

## Operation
- The FSM has three states:
  - IDLE to RUN when `start` is 1.
  - RUN to DONE after exactly `num_bits` RUN cycles.
  - DONE to RUN when `start` is 1, otherwise DONE to IDLE.
- On an accepted start:
  - `mcand` is loaded with `a` and `mplr` with `b`.
  - `acc_hi` (`num_bits+1` bits) is cleared.
  - The step counter `cnt` is cleared.
- Each RUN cycle:
  - If `mplr[0]` is 1, then `acc_hi = acc_hi + {0,mcand}`; otherwise `acc_hi` is unchanged.
  - `{acc_hi,mplr}` is then shifted right by 1, with 0 entering the MSB (unsigned).
  - `cnt` increments.
- On the RUN to DONE transition, `product` is loaded with `{acc_hi[num_bits-1:0], mplr}`.
- `start` is ignored in RUN. `a` and `b` may change freely after capture.
- An operand of 0 still takes the full `num_bits` cycles. There is no early exit.
- Unsigned arithmetic is exact: max×max = `2^(2n) - 2^(n+1) + 1`, with no overflow. The carry is held in `acc_hi[num_bits]`.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0. State is IDLE, and `cnt`, `acc_hi`, `mcand`, `mplr` are all 0.
- Latency: start is sampled at edge T. `busy` is 1 from T through T+`num_bits`. `done` and the new `product` are visible from T+`num_bits` for exactly one cycle (`done`). `product` persists after that.
- Back-to-back operation: `start` high during DONE is accepted at that edge. `busy` rises in the next cycle, so the throughput is one result per `num_bits+1` cycles.
- Reset asserted mid-RUN aborts the operation immediately (asynchronously). `product` returns to 0 and no `done` is produced.
- `cnt` width is `$clog2(num_bits+1)`. It compares to `num_bits-1` on the last RUN cycle, and it never wraps during normal operation.

## Configuration
- The macro is `SHIFT_ADD_MULT_SIGNED_EN`.
- When defined, operands and product are two's complement:
  - The add uses sign extension, `{mcand[n-1],mcand}`.
  - The right shift is arithmetic: the MSB of `acc_hi` is replicated.
  - On the final RUN step (`cnt`=`num_bits-1`), a `mplr[0]` of 1 causes `mcand` to be subtracted instead of added.
- When not defined, the block behaves as the unsigned design above. All ports, widths and latency are identical in both builds.

## Structure
- Package `mult_pkg` holds:
  - the state enum `mult_state_t` {IDLE, RUN, DONE};
  - the localparam for default width.
- One sub-module, `shift_add_step`, is natural. It is combinational: it takes `acc_hi`, `mplr`, `mcand` and a last-step flag, and returns the next `{acc_hi,mplr}`. The top module holds the FSM, the counter and the registers.

## Test plan
- Reset: hold `reset`=0 with `start`=1. `busy`=0, `done`=0, `product`=0, and there is no activity. Release reset; the block stays IDLE until `start` is asserted.
- Basic unsigned (n=8): `a`=13, `b`=11, `start` high for 1 cycle. `busy` is high for 8 cycles, then `done` pulses once with `product`=143.
- Extremes (n=8): 255×255 gives 65025. 0×200 gives 0, still after 8 busy cycles. 1×255 gives 255.
- Back-to-back and ignore: hold `start` high continuously with `a`=3, `b`=5, changing to `a`=7, `b`=9 mid-RUN. The results are 15 then 63. `done` pulses every 9 cycles. The mid-RUN operand change does not affect the first result.
- Reset mid-operation: assert `reset`=0 after 4 RUN cycles of 100×100. Outputs clear at once and no `done` follows. A new start with 2×3 then gives 6.
- Signed build (with `SHIFT_ADD_MULT_SIGNED_EN`, n=8):
  - −3×5 gives 16'hFFF1.
  - −128×−128 gives 16384.
  - 127×−1 gives 16'hFF81.
